// File: rtl/invtlb_seq.sv
// invtlb_seq: multi-cycle INVTLB sequencer.
// Walks every TLB entry through the single-index read port, evaluates the
// INVTLB match condition against the latched op/ASID/VA one cycle after each
// read, and clears the E bit of each matching entry through the invalidate port.
//
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   start, op, op_asid, op_va     request + operands (sampled only in IDLE)
//   busy, done, illegal           status; pipeline holds while busy
//   rd_en, rd_index               TLB read request
//   rd_e/g/asid/vppn/ps           read data, valid one cycle after rd_en
//   inv_we, inv_index             E-bit clear strobe
//   inv_count                     entries invalidated by the last op
module invtlb_seq #(
  parameter int TLBNUM     = 16,
  parameter int TLBNUMSIZE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4:0]            op,
  input  logic [9:0]            op_asid,
  input  logic [18:0]           op_va,
  output logic                  busy,
  output logic                  done,
  output logic                  illegal,
  output logic                  rd_en,
  output logic [TLBNUMSIZE-1:0] rd_index,
  input  logic                  rd_e,
  input  logic                  rd_g,
  input  logic [9:0]            rd_asid,
  input  logic [18:0]           rd_vppn,
  input  logic [5:0]            rd_ps,
  output logic                  inv_we,
  output logic [TLBNUMSIZE-1:0] inv_index,
  output logic [TLBNUMSIZE:0]   inv_count
);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_DRAIN, S_DONE} state_t;

  localparam logic [TLBNUMSIZE-1:0] LAST_IDX = TLBNUMSIZE'(TLBNUM - 1);

  state_t                state, state_nxt;
  logic [TLBNUMSIZE-1:0] ptr;
  logic [4:0]            op_q;
  logic [9:0]            asid_q;
  logic [18:0]           va_q;
  logic                  ill_q;
  // compare stage: index and valid of the read issued last cycle
  logic                  cmp_vld;
  logic [TLBNUMSIZE-1:0] cmp_idx;
  logic [TLBNUMSIZE:0]   cnt;

  logic op_ok;
  logic va_hit, asid_eq, match;

  assign op_ok = (op <= 5'd6);

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // ---------------- next state / control outputs ----------------
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    rd_en     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = op_ok ? S_WALK : S_DONE;
      end
      S_WALK: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (ptr == LAST_IDX) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // last entry's data arrives now; compare stage finishes it
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        illegal   = ill_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rd_index = ptr;

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr     <= '0;
      op_q    <= '0;
      asid_q  <= '0;
      va_q    <= '0;
      ill_q   <= 1'b0;
      cmp_vld <= 1'b0;
      cmp_idx <= '0;
      cnt     <= '0;
    end else begin
      cmp_vld <= (state == S_WALK);
      cmp_idx <= ptr;

      if (state == S_IDLE && start) begin
        ill_q <= ~op_ok;
        cnt   <= '0;
        if (op_ok) begin
          op_q   <= op;
          asid_q <= op_asid;
          va_q   <= op_va;
        end
      end else if (inv_we) begin
        cnt <= cnt + (TLBNUMSIZE+1)'(1);
      end

      // power-of-two entry count: natural wrap returns ptr to 0 after the last read
      if (state == S_WALK) ptr <= ptr + TLBNUMSIZE'(1);
    end
  end

  // ---------------- match evaluation ----------------
  always_comb begin
    va_hit = 1'b0;
    if (rd_ps == 6'd12)      va_hit = (rd_vppn == va_q);
    else if (rd_ps == 6'd21) va_hit = (rd_vppn[18:9] == va_q[18:9]);
  end

  assign asid_eq = (rd_asid == asid_q);

  always_comb begin
    match = 1'b0;
    unique case (op_q)
      5'd0, 5'd1: match = 1'b1;  // ops 0/1 ignore the E bit
      5'd2:       match = rd_e &  rd_g;
      5'd3:       match = rd_e & ~rd_g;
      5'd4:       match = rd_e & ~rd_g & asid_eq;
      5'd5:       match = rd_e & ~rd_g & asid_eq & va_hit;
      5'd6:       match = rd_e & (rd_g | asid_eq) & va_hit;
      default:    match = 1'b0;
    endcase
  end

  assign inv_we    = cmp_vld & match;
  assign inv_index = cmp_idx;
  assign inv_count = cnt;

endmodule

// File: doc/invtlb_seq.md
Name: invtlb_seq

Overview:
Multi-cycle sequencer that executes the INVTLB instruction against the TLB array. The CSR/TLB interface only supports single-index read, write and search. This block walks every TLB entry through the read port, evaluates the INVTLB match condition for the latched op/ASID/VA, and clears the E (valid) bit of each matching entry through a dedicated invalidate port. It sits beside the csr/tlb blocks in the WB stage; the pipeline stalls while `busy` is high.

Parameters:
TLBNUM, 16, number of TLB entries (power of 2)
TLBNUMSIZE, 4, log2(TLBNUM), index width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
start  in  1  one-cycle request to execute INVTLB; sampled only in IDLE
op  in  5  INVTLB op field
op_asid  in  10  rj[9:0] ASID operand
op_va  in  19  rk[31:13] VPPN operand
busy  out  1  walk in progress; pipeline must hold
done  out  1  one-cycle completion pulse
illegal  out  1  one-cycle pulse with done when op>6 (INE exception)
rd_en  out  1  TLB read request
rd_index  out  TLBNUMSIZE  entry to read
rd_e  in  1  E bit of entry, valid 1 cycle after rd_en
rd_g  in  1  G bit, same timing
rd_asid  in  10  entry ASID, same timing
rd_vppn  in  19  entry VPPN, same timing
rd_ps  in  6  entry page size (12 or 21), same timing
inv_we  out  1  clear E bit of inv_index this cycle
inv_index  out  TLBNUMSIZE  entry to invalidate
inv_count  out  TLBNUMSIZE+1  entries invalidated by last op; held until next start

Behaviour:
- Reset (async, reset=0): state=IDLE; busy, done, illegal, rd_en and inv_we are 0; rd_index, inv_index and inv_count are 0; latched operands are cleared. Reset mid-walk aborts immediately; no further inv_we is issued.
- States: IDLE, WALK, DRAIN, DONE.
- IDLE:
  - start=1 with op<=6: latch op, op_asid and op_va; clear inv_count; go to WALK.
  - start=1 with op>6: go to DONE with illegal flagged; no TLB access occurs.
  - start=0: stay in IDLE.
- WALK: rd_en=1, rd_index=ptr. ptr starts at 0 and increments every cycle. When ptr==TLBNUM-1 the next state is DRAIN; ptr wraps to 0.
- Compare stage (one cycle behind the read): a register holds the previous rd_index and a valid flag. The match is evaluated on rd_* in the cycle after each read. On match: inv_we=1, inv_index=held index, inv_count+=1.
- DRAIN: rd_en=0. Completes the compare for the last entry, then goes to DONE.
- DONE: done=1 (and illegal=1 if flagged) for exactly one cycle, then IDLE.
- busy=1 in WALK, DRAIN and DONE (not in IDLE). A start while busy is ignored.
- Match rules (entry must have rd_e=1, except ops 0/1, which match every entry unconditionally):
  - op0, op1: all entries.
  - op2: rd_g=1.
  - op3: rd_g=0.
  - op4: rd_g=0 and rd_asid==op_asid.
  - op5: rd_g=0 and rd_asid==op_asid and va_hit.
  - op6: (rd_g=1 or rd_asid==op_asid) and va_hit.
- va_hit:
  - rd_ps==12: rd_vppn[18:0]==op_va[18:0].
  - rd_ps==21: rd_vppn[18:9]==op_va[18:9].
  - Any other rd_ps: no hit.
- Latency for a legal op with start at edge T:
  - rd_en is high in cycles T+1..T+TLBNUM.
  - inv_we can occur in T+2..T+TLBNUM+1.
  - done is high in T+TLBNUM+2.
  - Total busy cycles: TLBNUM+2.
- Illegal op: busy and done both high in cycle T+1, illegal=1, inv_count=0.
- inv_we is never asserted outside the compare stage. At most one write per cycle and at most one write per entry per op.
- Operands are stable from latch; changes on op/op_asid/op_va during busy have no effect.

Test Plan:
- Op 0, 16 entries with mixed E/G: start -> rd_index 0..15 in cycles T+1..T+16; inv_we for all 16 indices in T+2..T+17; done at T+18; inv_count=16.
- Op 2, entries 3 and 9 with G=1 and E=1, entry 5 with G=1 and E=0: inv_we only at indices 3 and 9; inv_count=2.
- Op 5, op_asid=0x05, op_va=0x12345, plus mid-walk reset:
  - Expected matches: entry 4 (G=0, ASID=5, ps=12, vppn=0x12345) and entry 7 (ps=21, vppn=0x12200).
  - Non-matches: entry 8 (ASID=6) and entry 10 (G=1).
  - Result: invalidates 4 and 7; inv_count=2.
  - Reset drop at T+6: outputs go to 0 immediately; no inv_we is observed after reset.
- Op 6, op_asid=0x01: entry 2 (G=1, ASID=0x3FF, matching VA) is invalidated; entry 6 (G=0, ASID=2, matching VA) is not.
- Op 7: done=1, illegal=1 and busy=1 in T+1; rd_en and inv_we are never asserted; back in IDLE at T+2.
- Second start pulsed at T+5 during a walk: ignored; exactly one done pulse; a new start in the cycle after done is accepted.
